// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the boot/program-load controller.
// Holds the controller state encoding and the word-assembly geometry.
package boot_pkg;

  // Controller modes: fetch unit owns imem (RUN), UART image is being
  // written (LOAD), CPU held in reset before restarting at PC 0 (DONE).
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } boot_state_e;

  // Bytes assembled into one instruction word.
  localparam int BYTES_PER_WORD = 4;

endpackage : boot_pkg

// File: rtl/imem_boot_ctrl_word_asm.sv
// Byte-to-word assembler for the boot controller.
// Collects big-endian bytes (first byte lands in bits [31:24]) and emits a
// one-cycle word_valid_o pulse, with the word held on word_o, the cycle
// after the last byte of a word arrives. clear_i drops any partial word.
module boot_word_asm
  import boot_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] pushed;

  // Next-state: shift the new byte in, publish the word on the last byte.
  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    pushed       = {shift_q, byte_i};
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid_i) begin
      if (cnt_q == LAST_BYTE) begin
        word_d       = pushed;
        word_valid_d = 1'b1;
        cnt_d        = 2'd0;
        shift_d      = 24'd0;
      end else begin
        shift_d = pushed[23:0];
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= 2'd0;
      shift_q      <= 24'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule : boot_word_asm

// File: rtl/imem_boot_ctrl.sv
// Boot/program-load controller between UART RX, fetch unit and imem.
// RUN: fetch PC drives the imem address. A start_pg pulse enters LOAD,
// where UART bytes are packed into words written from address 0 upward
// while the CPU is held in reset. LOAD ends on an idle timeout (partial
// word dropped) or when memory is full; DONE then holds cpu_rst for
// RST_CYC cycles so the core restarts cleanly at PC 0.
// Optional build macro: IMEM_BOOT_XSUM_EN enables the XOR checksum of all
// accepted bytes on load_xsum; otherwise load_xsum is constant zero.
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 100000,
  parameter int RST_CYC     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic [31:0]       fetch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              loading,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        load_xsum
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RST_W = $clog2(RST_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RST_CYC - 1);
  // word_count value just before the write that fills the memory
  localparam logic [ADDR_W:0]   WC_LAST  = {1'b0, {ADDR_W{1'b1}}};

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              seen_q, seen_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              loading_q, loading_d;

  logic              asm_clear;
  logic              byte_accept;
  logic              full_exit;
  logic              asm_word_valid;
  logic [31:0]       asm_word;

  // Only the word-address bits of the byte PC select an imem location.
  logic              unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

  boot_word_asm u_word_asm (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (byte_accept),
    .byte_i       (rx_byte),
    .word_valid_o (asm_word_valid),
    .word_o       (asm_word)
  );

  // The assembler only sees bytes in LOAD; gating keeps writes inside LOAD
  // even for degenerate timeout settings.
  assign imem_we    = asm_word_valid && (state_q == LOAD);
  assign imem_wdata = asm_word;

  // FSM next-state, counters and the imem address mux.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    tmo_d        = tmo_q;
    seen_d       = seen_q;
    rst_cnt_d    = rst_cnt_q;
    asm_clear    = 1'b0;
    byte_accept  = 1'b0;
    full_exit    = 1'b0;
    imem_addr    = fetch_addr[ADDR_W+1:2];
    case (state_q)
      RUN: begin
        if (start_pg) begin
          state_d      = LOAD;
          wr_ptr_d     = '0;
          word_count_d = '0;
          tmo_d        = '0;
          seen_d       = 1'b0;
          asm_clear    = 1'b1;
        end
      end
      LOAD: begin
        imem_addr = wr_ptr_q;
        full_exit = imem_we && (word_count_q == WC_LAST);
        // Pointer advances after the write cycle completes.
        if (imem_we) begin
          wr_ptr_d     = wr_ptr_q + 1'b1;
          word_count_d = word_count_q + 1'b1;
        end
        if (full_exit) begin
          // Memory full: any byte arriving now belongs to no word.
          state_d   = DONE;
          rst_cnt_d = '0;
          asm_clear = 1'b1;
        end else if (rx_valid) begin
          // A byte on the terminal-count cycle keeps the session alive.
          byte_accept = 1'b1;
          seen_d      = 1'b1;
          tmo_d       = '0;
        end else if (seen_q) begin
          if (tmo_q == TMO_LAST) begin
            state_d   = DONE;
            rst_cnt_d = '0;
            asm_clear = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    cpu_rst_d = (state_d != RUN);
    loading_d = (state_d == LOAD);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      tmo_q        <= '0;
      seen_q       <= 1'b0;
      rst_cnt_q    <= '0;
      cpu_rst_q    <= 1'b0;
      loading_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      tmo_q        <= tmo_d;
      seen_q       <= seen_d;
      rst_cnt_q    <= rst_cnt_d;
      cpu_rst_q    <= cpu_rst_d;
      loading_q    <= loading_d;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign loading    = loading_q;
  assign word_count = word_count_q;

`ifdef IMEM_BOOT_XSUM_EN
  logic [7:0] xsum_q, xsum_d;

  // Running XOR of accepted bytes, restarted on each session entry.
  always_comb begin
    xsum_d = xsum_q;
    if (state_q == RUN && start_pg) begin
      xsum_d = 8'h00;
    end else if (byte_accept) begin
      xsum_d = xsum_q ^ rx_byte;
    end
  end

  // Checksum register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      xsum_q <= 8'h00;
    end else begin
      xsum_q <= xsum_d;
    end
  end

  assign load_xsum = xsum_q;
`else
  assign load_xsum = 8'h00;
`endif

endmodule : imem_boot_ctrl

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl with a small memory and short timeout.
// Stimulus feeds a session model that queues expected imem writes; a
// separate monitor pops and compares on every imem_we cycle.
module tb_imem_boot_ctrl;

  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 20;
  localparam int RST_CYC     = 4;
  localparam int DEPTH       = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              start_pg;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [31:0]       fetch_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_we;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              loading;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        load_xsum;

  imem_boot_ctrl #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RST_CYC     (RST_CYC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_pg   (start_pg),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .fetch_addr (fetch_addr),
    .imem_addr  (imem_addr),
    .imem_we    (imem_we),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .loading    (loading),
    .word_count (word_count),
    .load_xsum  (load_xsum)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_w;

  // Session model: what the loader should have done with the bytes sent.
  int          m_words;
  int          m_nb;
  logic [31:0] m_cur;
  logic [7:0]  m_xsum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_xsum();
`ifdef IMEM_BOOT_XSUM_EN
    return m_xsum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_start();
    m_words = 0;
    m_nb    = 0;
    m_cur   = 32'd0;
    m_xsum  = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    if (m_words < DEPTH) begin
      m_xsum = m_xsum ^ b;
      m_cur  = {m_cur[23:0], b};
      m_nb++;
      if (m_nb == 4) begin
        w.addr = ADDR_W'(m_words);
        w.data = m_cur;
        exp_q.push_back(w);
        m_words++;
        m_nb = 0;
      end
    end
  endtask

  task automatic start_session();
    start_pg = 1'b1;
    tick();
    start_pg = 1'b0;
    model_start();
    check("entry_loading", loading, 1);
    check("entry_cpu_rst", cpu_rst, 1);
    check("entry_imem_addr", imem_addr, 0);
    check("entry_word_count", word_count, 0);
    check("entry_xsum", load_xsum, 0);
  endtask

  // gap idle cycles (optionally with a start_pg pulse), then one byte.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    for (int i = 0; i < gap; i++) begin
      start_pg = pulse && (i == 0);
      tick();
    end
    start_pg = 1'b0;
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic finish_session(input bit by_timeout);
    int n;
    int r;
    n = 0;
    while (loading && n < TIMEOUT_CYC + 10) begin
      tick();
      n++;
    end
    if (by_timeout) begin
      check("timeout_cycles", n, TIMEOUT_CYC);
      r = 0;
      while (cpu_rst && r < RST_CYC + 10) begin
        r++;
        tick();
      end
      check("done_cpu_rst_cycles", r, RST_CYC);
    end else begin
      check("left_load", loading, 0);
      r = 0;
      while (cpu_rst && r < RST_CYC + 10) begin
        r++;
        tick();
      end
      check("cpu_rst_released", cpu_rst, 0);
    end
    fetch_addr = $urandom;
    #1;
    check("run_imem_addr", imem_addr, fetch_addr[ADDR_W+1:2]);
    check("run_imem_we", imem_we, 0);
    check("final_word_count", word_count, m_words);
    check("final_xsum", load_xsum, exp_xsum());
    check("writes_pending", exp_q.size(), 0);
  endtask

  // Write monitor: every imem_we cycle must match the next queued write.
  always @(negedge clock) begin
    if (!reset && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", imem_addr, imem_wdata);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_w.addr);
        check("wr_data", imem_wdata, mon_w.data);
        check("wr_in_load", loading, 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t2 [8];
    logic [7:0] t3 [5];
    int nb;
    t2 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    t3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    reset      = 1'b1;
    start_pg   = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    fetch_addr = 32'h0000_0010;
    model_start();
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and RUN address mapping
    check("rst_imem_addr", imem_addr, 4);
    check("rst_cpu_rst", cpu_rst, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_loading", loading, 0);
    check("rst_word_count", word_count, 0);
    check("rst_xsum", load_xsum, 0);
    tick();

    // Two full words then timeout
    start_session();
    foreach (t2[i]) send_byte(t2[i], $urandom_range(0, 3), 1'b0);
    finish_session(1'b1);
    check("t2_word_count", word_count, 2);

    // One word plus a dropped partial byte
    start_session();
    foreach (t3[i]) send_byte(t3[i], $urandom_range(0, 3), 1'b0);
    finish_session(1'b1);
    check("t3_word_count", word_count, 1);
`ifdef IMEM_BOOT_XSUM_EN
    check("t3_xsum", load_xsum, 8'h11);
`endif

    // Fill memory; the extra byte must be ignored
    start_session();
    for (int i = 0; i < DEPTH * 4 + 1; i++) send_byte(8'($urandom), $urandom_range(1, 3), 1'b0);
    finish_session(1'b0);
    check("full_word_count", word_count, DEPTH);

    // Reset in the middle of the second word
    start_session();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), $urandom_range(0, 2), 1'b0);
    reset = 1'b1;
    tick();
    check("midrst_imem_we", imem_we, 0);
    check("midrst_cpu_rst", cpu_rst, 0);
    check("midrst_loading", loading, 0);
    check("midrst_word_count", word_count, 0);
    check("midrst_imem_addr", imem_addr, fetch_addr[ADDR_W+1:2]);
    reset = 1'b0;
    repeat (3) tick();
    check("midrst_no_write", exp_q.size(), 0);

    // Byte on the would-be timeout cycle, start_pg pulse inside LOAD
    start_session();
    send_byte(8'hC3, 0, 1'b0);
    send_byte(8'h5A, 1, 1'b0);
    send_byte(8'h0F, TIMEOUT_CYC - 1, 1'b1);
    check("survived_timeout", loading, 1);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), $urandom_range(0, 3), i == 2);
    finish_session(1'b1);
    check("t6_word_count", word_count, 2);

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
      nb = $urandom_range(1, 24);
      start_session();
      for (int i = 0; i < nb; i++) send_byte(8'($urandom), $urandom_range(0, 3), 1'b0);
      finish_session(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_imem_boot_ctrl
